// File: rtl/vend_controller.sv
// Vending controller: accumulates coin credit against a latched product
// price, drives the dispenser handshake, and refunds change, cancelled
// credit or timed-out credit through a one-cycle change strobe.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no credit held, waiting for the first coin
// COLLECT  | credit below latched price, collecting coins, timeout active
// DISPENSE | credit covers price, dispense_req held until dispense_done
// CHANGE   | single cycle presenting the refund on change_amount
module vend_controller #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coin_valid,
  input  logic [3:0] coin_value,
  input  logic [3:0] coffee_price,
  input  logic       cancel,
  input  logic       dispense_done,
  output logic       dispense_req,
  output logic       change_valid,
  output logic [4:0] change_amount,
  output logic       coin_reject,
  output logic       LED_yellow,
  output logic       LED_green,
  output logic [4:0] sum_out
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] COLLECT  = 2'd1;
  localparam logic [1:0] DISPENSE = 2'd2;
  localparam logic [1:0] CHANGE   = 2'd3;

  // Reloaded with N-1 so the terminal count is hit after N idle cycles.
  localparam logic [15:0] TIMER_LOAD = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state_q, state_nxt;
  logic [4:0]  sum_q, sum_nxt;
  logic [3:0]  price_q, price_nxt;
  logic [15:0] timer_q, timer_nxt;
  logic        reject_nxt;
  logic        chg_nxt;
  logic [4:0]  amt_nxt;

  logic        coin_ok;
  logic [4:0]  sum_add;
  logic [4:0]  change_diff;

  // A zero-valued coin strobe is treated as no coin at all.
  assign coin_ok     = coin_valid && (coin_value != 4'd0);
  assign sum_add     = sum_q + {1'b0, coin_value};
  assign change_diff = sum_q - {1'b0, price_q};
  assign sum_out     = sum_q;

  // Next-state, credit, timer and strobe decisions.
  always_comb begin
    state_nxt  = state_q;
    sum_nxt    = sum_q;
    price_nxt  = price_q;
    timer_nxt  = timer_q;
    reject_nxt = 1'b0;
    chg_nxt    = 1'b0;
    amt_nxt    = 5'd0;
    case (state_q)
      IDLE: begin
        if (coin_ok) begin
          if (coffee_price == 4'd0) begin
            reject_nxt = 1'b1;
          end else begin
            sum_nxt   = {1'b0, coin_value};
            price_nxt = coffee_price;
            timer_nxt = TIMER_LOAD;
            state_nxt = (coin_value >= coffee_price) ? DISPENSE : COLLECT;
          end
        end
      end
      COLLECT: begin
        if (cancel) begin
          // Cancel takes priority and refunds any coin arriving with it.
          sum_nxt   = coin_ok ? sum_add : sum_q;
          chg_nxt   = 1'b1;
          amt_nxt   = coin_ok ? sum_add : sum_q;
          state_nxt = CHANGE;
        end else if (coin_ok) begin
          sum_nxt   = sum_add;
          timer_nxt = TIMER_LOAD;
          if (sum_add >= {1'b0, price_q}) state_nxt = DISPENSE;
        end else if (timer_q == 16'd0) begin
          chg_nxt   = 1'b1;
          amt_nxt   = sum_q;
          state_nxt = CHANGE;
        end else begin
          timer_nxt = timer_q - 16'd1;
        end
      end
      DISPENSE: begin
        reject_nxt = coin_ok;
        if (dispense_done) begin
          if (change_diff != 5'd0) begin
            chg_nxt   = 1'b1;
            amt_nxt   = change_diff;
            state_nxt = CHANGE;
          end else begin
            sum_nxt   = 5'd0;
            state_nxt = IDLE;
          end
        end
      end
      CHANGE: begin
        reject_nxt = coin_ok;
        sum_nxt    = 5'd0;
        state_nxt  = IDLE;
      end
      default: begin
        sum_nxt   = 5'd0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State, credit and registered outputs; outputs follow the new state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      sum_q         <= 5'd0;
      price_q       <= 4'd0;
      timer_q       <= 16'd0;
      dispense_req  <= 1'b0;
      change_valid  <= 1'b0;
      change_amount <= 5'd0;
      coin_reject   <= 1'b0;
      LED_yellow    <= 1'b0;
      LED_green     <= 1'b0;
    end else begin
      state_q       <= state_nxt;
      sum_q         <= sum_nxt;
      price_q       <= price_nxt;
      timer_q       <= timer_nxt;
      dispense_req  <= (state_nxt == DISPENSE);
      change_valid  <= chg_nxt;
      change_amount <= amt_nxt;
      coin_reject   <= reject_nxt;
      LED_yellow    <= (state_nxt == COLLECT);
      LED_green     <= (state_nxt == DISPENSE);
    end
  end

endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: directed vector table, hand-written corner
// sequences, then randomized traffic against a transaction-level model.
module tb_vend_controller;

  localparam int TIMEOUT = 5;

  logic       clk;
  logic       rst_n;
  logic       coin_valid;
  logic [3:0] coin_value;
  logic [3:0] coffee_price;
  logic       cancel;
  logic       dispense_done;
  logic       dispense_req;
  logic       change_valid;
  logic [4:0] change_amount;
  logic       coin_reject;
  logic       LED_yellow;
  logic       LED_green;
  logic [4:0] sum_out;

  vend_controller #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .coin_valid(coin_valid), .coin_value(coin_value),
    .coffee_price(coffee_price), .cancel(cancel), .dispense_done(dispense_done),
    .dispense_req(dispense_req), .change_valid(change_valid),
    .change_amount(change_amount), .coin_reject(coin_reject),
    .LED_yellow(LED_yellow), .LED_green(LED_green), .sum_out(sum_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output bundle: {req, chg_valid, chg_amount[5], reject, yellow, green, sum[5]}
  logic [14:0] act;
  assign act = {dispense_req, change_valid, change_amount, coin_reject,
                LED_yellow, LED_green, sum_out};

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, a, e);
    end
  endtask

  task automatic drive(input logic r, input logic cv, input logic [3:0] val,
                       input logic [3:0] pr, input logic can, input logic dn);
    rst_n = r; coin_valid = cv; coin_value = val;
    coffee_price = pr; cancel = can; dispense_done = dn;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       rst; logic cv; logic [3:0] val; logic [3:0] pr; logic can; logic dn;
    logic       req; logic chv; logic [4:0] amt; logic rej; logic yel; logic grn;
    logic [4:0] sum;
  } vec_t;

  vec_t vecs [17];

  // Transaction-level reference: customer phase, credit and idle run length.
  localparam int PH_IDLE = 0, PH_COLLECT = 1, PH_VEND = 2, PH_REFUND = 3;
  int m_phase, m_credit, m_price, m_idle, m_refund;
  bit m_reject;

  task automatic model_step(input logic r, input logic cv, input logic [3:0] val,
                            input logic [3:0] pr, input logic can, input logic dn);
    int v, p;
    bit coin;
    v = int'(val);
    p = int'(pr);
    coin = cv && (v != 0);
    m_reject = 0;
    m_refund = -1;
    if (!r) begin
      m_phase = PH_IDLE; m_credit = 0; m_price = 0; m_idle = 0;
    end else begin
      case (m_phase)
        PH_IDLE: if (coin) begin
          if (p == 0) m_reject = 1;
          else begin
            m_credit = v; m_price = p; m_idle = 0;
            m_phase = (v >= p) ? PH_VEND : PH_COLLECT;
          end
        end
        PH_COLLECT: begin
          if (can) begin
            if (coin) m_credit += v;
            m_refund = m_credit;
            m_phase = PH_REFUND;
          end else if (coin) begin
            m_credit += v;
            m_idle = 0;
            if (m_credit >= m_price) m_phase = PH_VEND;
          end else begin
            m_idle++;
            if (m_idle >= TIMEOUT) begin
              m_refund = m_credit;
              m_phase = PH_REFUND;
            end
          end
        end
        PH_VEND: begin
          m_reject = coin;
          if (dn) begin
            if (m_credit > m_price) begin
              m_refund = m_credit - m_price;
              m_phase = PH_REFUND;
            end else begin
              m_credit = 0;
              m_phase = PH_IDLE;
            end
          end
        end
        default: begin
          m_reject = coin;
          m_credit = 0;
          m_phase = PH_IDLE;
        end
      endcase
    end
  endtask

  function automatic logic [14:0] model_out();
    logic [4:0] amt;
    amt = (m_refund >= 0) ? 5'(m_refund) : 5'd0;
    return {m_phase == PH_VEND, m_refund >= 0, amt, m_reject,
            m_phase == PH_COLLECT, m_phase == PH_VEND, 5'(m_credit)};
  endfunction

  initial begin
    int n;
    logic cv, can, dn, r;
    logic [3:0] val, pr;

    //          rst  cv   val   price can  dn  | req  chv  amt    rej  yel  grn  sum
    vecs[0]  = '{1'b0,1'b1,4'd5,4'd7,1'b1,1'b1, 1'b0,1'b0,5'd0,1'b0,1'b0,1'b0,5'd0};
    vecs[1]  = '{1'b1,1'b1,4'd5,4'd7,1'b0,1'b0, 1'b0,1'b0,5'd0,1'b0,1'b1,1'b0,5'd5};
    vecs[2]  = '{1'b1,1'b1,4'd5,4'd7,1'b0,1'b0, 1'b1,1'b0,5'd0,1'b0,1'b0,1'b1,5'd10};
    vecs[3]  = '{1'b1,1'b0,4'd0,4'd7,1'b0,1'b0, 1'b1,1'b0,5'd0,1'b0,1'b0,1'b1,5'd10};
    vecs[4]  = '{1'b1,1'b0,4'd0,4'd7,1'b1,1'b0, 1'b1,1'b0,5'd0,1'b0,1'b0,1'b1,5'd10};
    vecs[5]  = '{1'b1,1'b0,4'd0,4'd7,1'b0,1'b1, 1'b0,1'b1,5'd3,1'b0,1'b0,1'b0,5'd10};
    vecs[6]  = '{1'b1,1'b0,4'd0,4'd7,1'b0,1'b0, 1'b0,1'b0,5'd0,1'b0,1'b0,1'b0,5'd0};
    vecs[7]  = '{1'b1,1'b1,4'd4,4'd4,1'b0,1'b0, 1'b1,1'b0,5'd0,1'b0,1'b0,1'b1,5'd4};
    vecs[8]  = '{1'b1,1'b0,4'd0,4'd4,1'b0,1'b1, 1'b0,1'b0,5'd0,1'b0,1'b0,1'b0,5'd0};
    vecs[9]  = '{1'b1,1'b0,4'd0,4'd4,1'b0,1'b0, 1'b0,1'b0,5'd0,1'b0,1'b0,1'b0,5'd0};
    vecs[10] = '{1'b1,1'b1,4'd6,4'd9,1'b0,1'b0, 1'b0,1'b0,5'd0,1'b0,1'b1,1'b0,5'd6};
    vecs[11] = '{1'b1,1'b1,4'd3,4'd9,1'b1,1'b0, 1'b0,1'b1,5'd9,1'b0,1'b0,1'b0,5'd9};
    vecs[12] = '{1'b1,1'b1,4'd5,4'd9,1'b0,1'b0, 1'b0,1'b0,5'd0,1'b1,1'b0,1'b0,5'd0};
    vecs[13] = '{1'b1,1'b1,4'd5,4'd0,1'b0,1'b0, 1'b0,1'b0,5'd0,1'b1,1'b0,1'b0,5'd0};
    vecs[14] = '{1'b1,1'b0,4'd0,4'd0,1'b0,1'b0, 1'b0,1'b0,5'd0,1'b0,1'b0,1'b0,5'd0};
    vecs[15] = '{1'b1,1'b1,4'd0,4'd5,1'b0,1'b0, 1'b0,1'b0,5'd0,1'b0,1'b0,1'b0,5'd0};
    vecs[16] = '{1'b1,1'b0,4'd0,4'd5,1'b1,1'b1, 1'b0,1'b0,5'd0,1'b0,1'b0,1'b0,5'd0};

    drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 32'(act), 32'd0);

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].rst, vecs[i].cv, vecs[i].val, vecs[i].pr, vecs[i].can, vecs[i].dn);
      step();
      check($sformatf("vec%0d", i), 32'(act),
            32'({vecs[i].req, vecs[i].chv, vecs[i].amt, vecs[i].rej,
                 vecs[i].yel, vecs[i].grn, vecs[i].sum}));
    end

    // Timeout: coin 2 against price 9, then silence until refund.
    drive(1'b1, 1'b1, 4'd2, 4'd9, 1'b0, 1'b0);
    step();
    check("timeout_collect", 32'(act), 32'({1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd2}));
    drive(1'b1, 1'b0, 4'd0, 4'd9, 1'b0, 1'b0);
    n = 1;
    while (!change_valid && n < 20) begin
      step();
      n++;
    end
    check("timeout_cycle", 32'(n), 32'd6);
    check("timeout_amount", 32'(change_amount), 32'd2);
    step();
    check("timeout_idle", 32'(act), 32'd0);

    // Coin and cancel during DISPENSE, then reset mid-DISPENSE.
    drive(1'b1, 1'b1, 4'd3, 4'd3, 1'b0, 1'b0);
    step();
    check("disp_enter", 32'(act), 32'({1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd3}));
    drive(1'b1, 1'b1, 4'd5, 4'd3, 1'b1, 1'b0);
    step();
    check("disp_reject", 32'(act), 32'({1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3}));
    drive(1'b0, 1'b1, 4'd7, 4'd3, 1'b0, 1'b1);
    step();
    check("reset_mid_disp", 32'(act), 32'd0);
    drive(1'b1, 1'b0, 4'd0, 4'd3, 1'b0, 1'b0);
    step();
    check("after_reset_quiet", 32'(act), 32'd0);
    drive(1'b1, 1'b1, 4'd4, 4'd9, 1'b0, 1'b0);
    step();
    check("first_coin_after_reset", 32'(act), 32'({1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd4}));
    drive(1'b1, 1'b0, 4'd0, 4'd1, 1'b1, 1'b0);
    step();
    check("cancel_refund", 32'(act), 32'({1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 5'd4}));
    drive(1'b1, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0);
    step();
    check("cancel_idle", 32'(act), 32'd0);

    // Randomized traffic against the reference model.
    pr = 4'd6;
    for (int i = 0; i < 3000; i++) begin
      r   = (i == 0) ? 1'b0 : ($urandom_range(0, 199) != 0);
      cv  = ($urandom_range(0, 9) < 3);
      val = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) pr = 4'($urandom_range(0, 15));
      can = ($urandom_range(0, 19) == 0);
      dn  = ($urandom_range(0, 3) == 0);
      drive(r, cv, val, pr, can, dn);
      step();
      model_step(r, cv, val, pr, can, dn);
      check($sformatf("rand%0d", i), 32'(act), 32'(model_out()));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
